// File: rtl/ula_float_pkg.sv
// Shared float ALU definitions: mantissa widths, divider FSM encoding
// and the quotient pattern reported on divide-by-zero.
package ula_float_pkg;

  localparam int WIDTH_DEF     = 27;
  localparam int FRAC_BITS_DEF = 26;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_RUN    = 2'd1;
  localparam state_t ST_FINISH = 2'd2;

  // Every quotient bit is set on divide-by-zero.
  localparam logic DIV_ZERO_Q_FILL = 1'b1;

endpackage

// File: rtl/ula_float_div_step.sv
// One restoring division iteration: shift in a dividend bit,
// trial-subtract the divisor, emit one quotient bit.
module ula_float_div_step #(
  parameter int WIDTH = 27
) (
  input  logic [WIDTH:0]   partial_i,
  input  logic             msb_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   partial_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] p;
  logic [WIDTH:0] dvs_ext;
  logic           unused_top;

  // Partial stays below divisor, so its top bit is always clear.
  assign unused_top = partial_i[WIDTH];

  always_comb begin
    p         = {partial_i[WIDTH-1:0], msb_i};
    dvs_ext   = {1'b0, divisor_i};
    q_bit_o   = (p >= dvs_ext);
    partial_o = q_bit_o ? (p - dvs_ext) : p;
  end

endmodule

// File: rtl/ula_float_divisor.sv
// Restoring shift-subtract mantissa divider, one quotient bit per clock.
// Optional sticky output enabled with ULA_FLOAT_DIV_STICKY_EN.
module ula_float_divisor
  import ula_float_pkg::*;
#(
  parameter  int WIDTH     = WIDTH_DEF,
  parameter  int FRAC_BITS = FRAC_BITS_DEF,
  localparam int QW        = WIDTH + FRAC_BITS,
  localparam int CW        = $clog2(QW + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividendo,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [QW-1:0]    quociente,
  output logic [WIDTH-1:0] resto,
  output logic             div_zero
`ifdef ULA_FLOAT_DIV_STICKY_EN
  ,
  output logic             sticky
`endif
);

  state_t           state_q, state_d;
  logic [QW-1:0]    dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH:0]   part_q, part_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dzw_q, dzw_d;
  logic [QW-1:0]    quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;
  logic [WIDTH:0]   part_nxt;
  logic             q_bit;

  ula_float_div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .partial_i(part_q),
    .msb_i    (dvd_q[QW-1]),
    .divisor_i(dvs_q),
    .partial_o(part_nxt),
    .q_bit_o  (q_bit)
  );

  // The dividend register doubles as the quotient accumulator.
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    part_d  = part_q;
    cnt_d   = cnt_q;
    dzw_d   = dzw_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    unique case (1'b1)
      (state_q == ST_IDLE): begin
        if (start) begin
          if (divisor != '0) begin
            state_d = ST_RUN;
            dvd_d   = {dividendo, {FRAC_BITS{1'b0}}};
            dvs_d   = divisor;
            part_d  = '0;
            cnt_d   = CW'(QW);
            dzw_d   = 1'b0;
          end else begin
            state_d = ST_FINISH;
            dvd_d   = {QW{DIV_ZERO_Q_FILL}};
            dvs_d   = divisor;
            part_d  = {1'b0, dividendo};
            cnt_d   = '0;
            dzw_d   = 1'b1;
          end
        end
      end
      (state_q == ST_RUN): begin
        dvd_d  = {dvd_q[QW-2:0], q_bit};
        part_d = part_nxt;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == CW'(1))
          state_d = ST_FINISH;
      end
      (state_q == ST_FINISH): begin
        quo_d   = dvd_q;
        rem_d   = part_q[WIDTH-1:0];
        dz_d    = dzw_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      part_q  <= '0;
      cnt_q   <= '0;
      dzw_q   <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      part_q  <= part_d;
      cnt_q   <= cnt_d;
      dzw_q   <= dzw_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

`ifdef ULA_FLOAT_DIV_STICKY_EN
  logic sticky_q, sticky_d;

  always_comb begin
    sticky_d = sticky_q;
    if (state_q == ST_FINISH)
      sticky_d = |part_q[WIDTH-1:0];
  end

  always_ff @(posedge clock) begin
    if (reset) sticky_q <= 1'b0;
    else       sticky_q <= sticky_d;
  end

  assign sticky = sticky_q;
`endif

  assign busy      = (state_q == ST_RUN);
  assign done      = done_q;
  assign quociente = quo_q;
  assign resto     = rem_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_ula_float_divisor.sv
// Directed bench for ula_float_divisor: vector table plus hand-written
// sequences for ignored start and mid-operation reset.
module tb_ula_float_divisor;

  localparam int WIDTH = 27;
  localparam int QW    = 53;

  logic             clock = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] dividendo;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [QW-1:0]    quociente;
  logic [WIDTH-1:0] resto;
  logic             div_zero;
`ifdef ULA_FLOAT_DIV_STICKY_EN
  logic             sticky;
`endif

  ula_float_divisor dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .dividendo(dividendo),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .quociente(quociente),
    .resto    (resto),
    .div_zero (div_zero)
`ifdef ULA_FLOAT_DIV_STICKY_EN
    ,
    .sticky   (sticky)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dvs;
    logic [QW-1:0]    q;
    logic [WIDTH-1:0] r;
    logic             dz;
    int               lat;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic start_pulse(input logic [WIDTH-1:0] a,
                             input logic [WIDTH-1:0] b);
    @(negedge clock);
    dividendo = a;
    divisor   = b;
    start     = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  // Called right after the start edge; counts edges until done.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = -1;
    busy_cnt = busy ? 1 : 0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clock);
      #1;
      if (done) begin
        lat = n;
        break;
      end
      if (busy) busy_cnt++;
    end
  endtask

  vec_t vecs[8];
  int   lat, bcnt, dcnt;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    dividendo = '0;
    divisor = '0;

    vecs[0] = '{27'h4000000, 27'h4000000, 53'h4000000, 27'h0, 1'b0, 54};
    vecs[1] = '{27'h6000000, 27'h4000000, 53'h6000000, 27'h0, 1'b0, 54};
    vecs[2] = '{27'h4000000, 27'h6000000, 53'h2AAAAAA, 27'h4000000, 1'b0, 54};
    vecs[3] = '{27'h0000005, 27'h0, {QW{1'b1}}, 27'h5, 1'b1, 1};
    vecs[4] = '{27'h0000007, 27'h3, 53'h9555555, 27'h1, 1'b0, 54};
    vecs[5] = '{27'h7FFFFFF, 27'h1, 53'h1FFFFFFC000000, 27'h0, 1'b0, 54};
    vecs[6] = '{27'h0, 27'h5, 53'h0, 27'h0, 1'b0, 54};
    vecs[7] = '{27'h0, 27'h0, {QW{1'b1}}, 27'h0, 1'b1, 1};

    repeat (3) @(posedge clock);
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_quo", 64'(quociente), 64'd0);
    chk("reset_rem", 64'(resto), 64'd0);
    chk("reset_dz", 64'(div_zero), 64'd0);
`ifdef ULA_FLOAT_DIV_STICKY_EN
    chk("reset_sticky", 64'(sticky), 64'd0);
`endif
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      start_pulse(vecs[i].dvd, vecs[i].dvs);
      wait_done(lat, bcnt);
      chk($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("v%0d_busy", i), 64'(bcnt),
          64'(vecs[i].lat == 1 ? 0 : QW));
      chk($sformatf("v%0d_quo", i), 64'(quociente), 64'(vecs[i].q));
      chk($sformatf("v%0d_rem", i), 64'(resto), 64'(vecs[i].r));
      chk($sformatf("v%0d_dz", i), 64'(div_zero), 64'(vecs[i].dz));
`ifdef ULA_FLOAT_DIV_STICKY_EN
      chk($sformatf("v%0d_sticky", i), 64'(sticky), 64'(vecs[i].r != 0));
`endif
      @(posedge clock);
      #1;
      chk($sformatf("v%0d_done_pulse", i), 64'(done), 64'd0);
      chk($sformatf("v%0d_hold_quo", i), 64'(quociente), 64'(vecs[i].q));
    end

    // Second start during RUN must be dropped.
    start_pulse(27'h6000000, 27'h4000000);
    repeat (9) @(posedge clock);
    start_pulse(27'h4000000, 27'h6000000);
    wait_done(lat, bcnt);
    chk("ign_latency", 64'(lat + 10), 64'd54);
    chk("ign_quo", 64'(quociente), 64'h6000000);
    chk("ign_rem", 64'(resto), 64'h0);
    repeat (3) @(posedge clock);
    #1;
    chk("ign_idle", 64'(busy), 64'd0);

    // Reset in the middle of a run aborts it silently.
    start_pulse(27'h4000000, 27'h6000000);
    repeat (19) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    start = 1'b1;
    @(posedge clock);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_quo", 64'(quociente), 64'd0);
    chk("rst_rem", 64'(resto), 64'd0);
    chk("rst_dz", 64'(div_zero), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    start = 1'b0;
    dcnt = 0;
    for (int n = 0; n < 70; n++) begin
      @(posedge clock);
      #1;
      if (done || busy) dcnt++;
    end
    chk("rst_no_done", 64'(dcnt), 64'd0);

    start_pulse(27'h4000000, 27'h6000000);
    wait_done(lat, bcnt);
    chk("post_rst_latency", 64'(lat), 64'd54);
    chk("post_rst_quo", 64'(quociente), 64'h2AAAAAA);
    chk("post_rst_rem", 64'(resto), 64'h4000000);
    chk("post_rst_dz", 64'(div_zero), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
